// File: rtl/key_conditioner.sv
// N-channel push-button conditioner: synchroniser, debounce, press/release pulses,
// long-press detection and per-channel auto-repeat.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_active
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned HoldW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] LongLast = HoldW'((LONG_CYCLES == 0) ? 0 : LONG_CYCLES - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);
  localparam bit               LongEn   = (LONG_CYCLES != 0);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLong
  } hold_state_e;

  logic [N_KEYS-1:0] raw;

  assign raw = ACTIVE_HIGH ? key_in : ~key_in;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   stable_q, stable_d;
    logic [DbW-1:0]         db_cnt_q, db_cnt_d;
    logic                   level_q;
    logic                   press_q, release_q;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    logic                   press_ev, release_ev;
    hold_state_e            state_q, state_d;
    logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]        rep_cnt_q, rep_cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
      end
    end

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      if (sync_out != stable_q) begin
        if (db_cnt_q == DbLast) begin
          stable_d = ~stable_q;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
    end

    // level_q lags stable_q by one cycle, so the edge events line up with key_level.
    assign press_ev   = stable_q & ~level_q;
    assign release_ev = ~stable_q & level_q;

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      if (release_ev) begin
        // Release beats any long/repeat threshold reached on the same cycle.
        state_d    = StIdle;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end else if (press_ev) begin
        state_d    = StPressed;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end
          StPressed: begin
            if (LongEn && (hold_cnt_q == LongLast)) begin
              state_d   = StLong;
              long_d    = 1'b1;
              rep_cnt_d = '0;
            end else if (hold_cnt_q != {HoldW{1'b1}}) begin
              hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
          end
          StLong: begin
            if (!repeat_en[i]) begin
              rep_cnt_d = '0;
            end else if (rep_cnt_q == RepLast) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + RepW'(1);
            end
          end
          default: begin
            state_d    = StIdle;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q   <= 1'b0;
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
        state_q    <= StIdle;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
      end else begin
        stable_q   <= stable_d;
        db_cnt_q   <= db_cnt_d;
        level_q    <= stable_q;
        press_q    <= press_ev;
        release_q  <= release_ev;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
      end
    end

    assign key_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
    assign repeat_pulse[i]  = repeat_q;
  end

  assign any_active = |key_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: an active-high and an active-low instance driven with mirrored
// stimulus, checked every cycle against a history-window / timestamp reference model.
module tb_key_conditioner;

  localparam int NK = 5;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in, key_in_n, repeat_en;
  logic [NK-1:0] level_a, press_a, rel_a, long_a, rep_a;
  logic [NK-1:0] level_b, press_b, rel_b, long_b, rep_b;
  logic          any_a, any_b;

  assign key_in_n = ~key_in;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
    .REPEAT_CYCLES(RC), .ACTIVE_HIGH(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .repeat_en(repeat_en),
    .key_level(level_a), .press_pulse(press_a), .release_pulse(rel_a),
    .long_pulse(long_a), .repeat_pulse(rep_a), .any_active(any_a)
  );

  key_conditioner #(
    .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
    .REPEAT_CYCLES(RC), .ACTIVE_HIGH(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_n), .repeat_en(repeat_en),
    .key_level(level_b), .press_pulse(press_b), .release_pulse(rel_b),
    .long_pulse(long_b), .repeat_pulse(rep_b), .any_active(any_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: raw history per edge, accepted level from a window rule, hold behaviour
  // from press/long/repeat timestamps.
  logic [NK-1:0] raw_hist[$];
  logic [NK-1:0] stable_m, level_m;
  logic [NK-1:0] exp_level, exp_press, exp_rel, exp_long, exp_rep;
  bit            in_press[NK];
  bit            in_long[NK];
  int            press_t[NK];
  int            anchor[NK];

  task automatic model_reset();
    raw_hist.delete();
    stable_m  = '0;
    level_m   = '0;
    exp_level = '0;
    exp_press = '0;
    exp_rel   = '0;
    exp_long  = '0;
    exp_rep   = '0;
    for (int c = 0; c < NK; c++) begin
      in_press[c] = 1'b0;
      in_long[c]  = 1'b0;
      press_t[c]  = 0;
      anchor[c]   = 0;
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] nxt, smp;
    int t, idx;
    bit all_diff, s;
    raw_hist.push_back(key_in);
    t   = raw_hist.size() - 1;
    nxt = stable_m;
    // Level flips once the last DB synchroniser outputs all disagree with it.
    for (int c = 0; c < NK; c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        idx = t - SS - j;
        if (idx >= 0) begin
          smp = raw_hist[idx];
          s   = smp[c];
        end else begin
          s = 1'b0;
        end
        if (s == stable_m[c]) all_diff = 1'b0;
      end
      if (all_diff) nxt[c] = ~stable_m[c];
    end
    exp_press = stable_m & ~level_m;
    exp_rel   = ~stable_m & level_m;
    exp_level = stable_m;
    exp_long  = '0;
    exp_rep   = '0;
    for (int c = 0; c < NK; c++) begin
      if (exp_rel[c]) begin
        in_press[c] = 1'b0;
        in_long[c]  = 1'b0;
      end else if (exp_press[c]) begin
        in_press[c] = 1'b1;
        in_long[c]  = 1'b0;
        press_t[c]  = t;
      end else if (in_press[c] && !in_long[c]) begin
        if (t - press_t[c] == LC) begin
          exp_long[c] = 1'b1;
          in_long[c]  = 1'b1;
          anchor[c]   = t;
        end
      end else if (in_long[c]) begin
        if (!repeat_en[c]) begin
          anchor[c] = t;
        end else if (t - anchor[c] == RC) begin
          exp_rep[c] = 1'b1;
          anchor[c]  = t;
        end
      end
    end
    level_m  = stable_m;
    stable_m = nxt;
  endtask

  task automatic compare_all();
    chk("level_a", level_a, exp_level);
    chk("press_a", press_a, exp_press);
    chk("release_a", rel_a, exp_rel);
    chk("long_a", long_a, exp_long);
    chk("repeat_a", rep_a, exp_rep);
    chk("any_a", any_a, |exp_level);
    chk("level_b", level_b, exp_level);
    chk("press_b", press_b, exp_press);
    chk("release_b", rel_b, exp_rel);
    chk("long_b", long_b, exp_long);
    chk("repeat_b", rep_b, exp_rep);
    chk("any_b", any_b, |exp_level);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic settle(input int n);
    key_in = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    int ch;
    int hold;
    bit rep;
    int press_at;
    int rel_at;
    int long_n;
    int long_at;
    int rep_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int np, pa, nr, ra, nl, la, nrp;
    vecs[0] = '{ch: 0, hold: 30, rep: 1'b1, press_at: 6, rel_at: 36, long_n: 1, long_at: 26, rep_n: 1};
    vecs[1] = '{ch: 2, hold: 60, rep: 1'b1, press_at: 6, rel_at: 66, long_n: 1, long_at: 26, rep_n: 7};
    vecs[2] = '{ch: 2, hold: 60, rep: 1'b0, press_at: 6, rel_at: 66, long_n: 1, long_at: 26, rep_n: 0};
    vecs[3] = '{ch: 3, hold: 10, rep: 1'b1, press_at: 6, rel_at: 16, long_n: 0, long_at: -1, rep_n: 0};
    vecs[4] = '{ch: 3, hold: 20, rep: 1'b1, press_at: 6, rel_at: 26, long_n: 0, long_at: -1, rep_n: 0};
    vecs[5] = '{ch: 4, hold: 21, rep: 1'b1, press_at: 6, rel_at: 27, long_n: 1, long_at: 26, rep_n: 0};
    vecs[6] = '{ch: 1, hold: 25, rep: 1'b1, press_at: 6, rel_at: 31, long_n: 1, long_at: 26, rep_n: 0};

    rst_n     = 1'b0;
    key_in    = '0;
    repeat_en = '0;
    model_reset();
    #3;
    compare_all();
    #9 rst_n = 1'b1;
    settle(5);

    // Table-driven single-channel holds.
    foreach (vecs[v]) begin
      repeat_en = '0;
      repeat_en[vecs[v].ch] = vecs[v].rep;
      settle(12);
      np = 0; pa = -1; nr = 0; ra = -1; nl = 0; la = -1; nrp = 0;
      key_in[vecs[v].ch] = 1'b1;
      for (int k = 0; k < vecs[v].hold + 20; k++) begin
        if (k == vecs[v].hold) key_in[vecs[v].ch] = 1'b0;
        step();
        if (press_a[vecs[v].ch]) begin np++; if (pa < 0) pa = k; end
        if (rel_a[vecs[v].ch]) begin nr++; if (ra < 0) ra = k; end
        if (long_a[vecs[v].ch]) begin nl++; if (la < 0) la = k; end
        if (rep_a[vecs[v].ch]) nrp++;
      end
      chk($sformatf("vec%0d press_count", v), np, 1);
      chk($sformatf("vec%0d press_time", v), pa, vecs[v].press_at);
      chk($sformatf("vec%0d release_count", v), nr, 1);
      chk($sformatf("vec%0d release_time", v), ra, vecs[v].rel_at);
      chk($sformatf("vec%0d long_count", v), nl, vecs[v].long_n);
      chk($sformatf("vec%0d long_time", v), la, vecs[v].long_at);
      chk($sformatf("vec%0d repeat_count", v), nrp, vecs[v].rep_n);
    end

    // Bounce on channel 1: 2-cycle toggles for 12 cycles, then held high.
    repeat_en = '0;
    settle(12);
    np = 0; pa = -1;
    for (int k = 0; k < 30; k++) begin
      key_in[1] = (k >= 12) ? 1'b1 : (((k / 2) % 2) == 0);
      step();
      if (press_a[1]) begin np++; if (pa < 0) pa = k; end
    end
    chk("bounce press_count", np, 1);
    chk("bounce press_time", pa, 18);

    // Channels 0 and 4 rise together.
    settle(12);
    key_in = 5'b10001;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 6) begin
        chk("simul press_a", press_a, 5'b10001);
        chk("simul press_b", press_b, 5'b10001);
      end
    end

    // Asynchronous reset while channel 2 is in LONG, key held across it.
    settle(12);
    repeat_en = 5'b00100;
    key_in    = 5'b00100;
    for (int k = 0; k < 30; k++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst level_a", level_a, '0);
    chk("rst press_a", press_a | rel_a | long_a | rep_a, '0);
    chk("rst any_a", any_a, 1'b0);
    chk("rst level_b", level_b, '0);
    chk("rst pulses_b", press_b | rel_b | long_b | rep_b, '0);
    chk("rst any_b", any_b, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    np = 0; pa = -1; nl = 0; la = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (press_a[2]) begin np++; if (pa < 0) pa = k; end
      if (long_a[2]) begin nl++; if (la < 0) la = k; end
    end
    chk("post-reset press_count", np, 1);
    chk("post-reset press_time", pa, 6);
    chk("post-reset long_count", nl, 1);
    chk("post-reset long_time", la, 26);

    // Random stimulus with quiet and noisy phases.
    settle(12);
    for (int k = 0; k < 3000; k++) begin
      int p;
      p = (((k / 200) % 3) == 0) ? 30 : 3;
      for (int c = 0; c < NK; c++) begin
        if ($urandom_range(0, 99) < p) key_in[c] = ~key_in[c];
      end
      if ($urandom_range(0, 49) == 0) repeat_en[$urandom_range(0, NK - 1)] ^= 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
